// File: rtl/alsu_result_collector.sv
// rtl/alsu_result_collector.sv - collects ALSU results into an FWFT FIFO with saturating sum, error and drop counters
module alsu_result_collector #(
    parameter int DEPTH = 8,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [5:0]               out_in,
    input  logic [15:0]              leds_in,
    input  logic                     rd_en,
    output logic [6:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ACC_W-1:0]         sum_acc,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [6:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          inv;
    logic          push;
    logic          pop;
    logic          drop;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;

    // A full FIFO still accepts a push when the reader frees a slot in the same cycle
    assign inv  = |leds_in;
    assign push = in_valid & (~full | rd_en);
    assign pop  = rd_en & ~empty;
    assign drop = in_valid & full & ~rd_en;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rd_data = mem[rd_ptr];

    // Add one guard bit, then clamp when the guard and sign bits disagree
    always_comb begin
        sum_wide = {sum_acc[ACC_W-1], sum_acc} + {{(ACC_W-5){out_in[5]}}, out_in};
        sum_sat  = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sat = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Storage array; contents are don't-care after reset since pointers restart
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {inv, out_in};
        end
    end

    // Pointers and occupancy; count is kept explicitly so flags decode from one register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Running sum of valid results (including dropped ones) and saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_acc  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
            dropped  <= 1'b0;
        end else begin
            if (in_valid && !inv) begin
                sum_acc <= sum_sat;
            end
            if (in_valid && inv && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (drop) begin
                dropped <= 1'b1;
                if (drop_cnt != {CNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule
